// File: rtl/syn_sum_pipe.sv
// syn_sum_pipe
//   Two-stage valid/ready pipelined four-operand adder/subtractor.
//   Stage 1 forms the pair sums p = a+b+cin and q = c+d (WIDTH+1 bits each).
//   Stage 2 forms total = p+q or p-q (WIDTH+2 bits) and registers the result.
//   The result is either wrapping (low bits plus a 2-bit carry-out) or
//   saturating, selected by SAT.
//
// Parameters
//   WIDTH      operand and sum width (>= 2)
//   SAT        0: wrapping result with cout, 1: saturating result, cout = 0
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b, c, d unsigned operands
//   cin        carry-in added to the a+b pair
//   sub        0: a+b+c+d+cin, 1: (a+b+cin)-(c+d)
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result low WIDTH bits
//   cout       result bits [WIDTH+1:WIDTH]
//   ovf        result outside the unsigned WIDTH range

module syn_sum_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [1:0]       cout,
    output logic             ovf
);

    // ------------------------------------------------------------------
    // Handshake / load control
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_load;
    logic s2_load;

    // A stage loads when it is empty or its current beat leaves this cycle.
    assign s2_load = !s2_valid_q || out_ready;
    assign s1_load = !s1_valid_q || s2_load;

    // Held low during reset so nothing is accepted while the pipe is cleared.
    assign in_ready  = s1_load && !rst;
    assign out_valid = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: pair sums
    // ------------------------------------------------------------------
    logic [WIDTH:0] p_d;
    logic [WIDTH:0] q_d;
    logic [WIDTH:0] p_q;
    logic [WIDTH:0] q_q;
    logic           sub_q;

    always_comb begin
        p_d = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        q_d = {1'b0, c} + {1'b0, d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            q_q        <= '0;
            sub_q      <= 1'b0;
        end else if (s1_load) begin
            // Clears the flag when the held beat moves on and nothing replaces it.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q   <= p_d;
                q_q   <= q_d;
                sub_q <= sub;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine pair sums, format result
    // ------------------------------------------------------------------
    logic [WIDTH+1:0] p_ext;
    logic [WIDTH+1:0] q_ext;
    logic [WIDTH+1:0] total;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;
    logic [1:0]       cout_d;

    logic [WIDTH-1:0] sum_q;
    logic [1:0]       cout_q;
    logic             ovf_q;

    always_comb begin
        p_ext = {1'b0, p_q};
        q_ext = {1'b0, q_q};
        // Subtraction wraps modulo 2^(WIDTH+2).
        total = sub_q ? (p_ext - q_ext) : (p_ext + q_ext);

        // Add overflows past WIDTH bits; subtract underflows when p < q.
        ovf_d = sub_q ? (p_q < q_q) : (total[WIDTH+1:WIDTH] != 2'b00);

        sum_d  = total[WIDTH-1:0];
        cout_d = total[WIDTH+1:WIDTH];

        if (SAT) begin
            cout_d = 2'b00;
            if (ovf_d) begin
                // Clamp to the range edge on the side the result left.
                sum_d = sub_q ? '0 : '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 2'b00;
            ovf_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            // Result registers only change when a real beat moves in, so the
            // outputs stay stable while stalled or idle.
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_syn_sum_pipe.sv
// tb_syn_sum_pipe
//   Directed bench for syn_sum_pipe at WIDTH=8. Two instances share the
//   stimulus: dut0 with SAT=0 (wrapping) and dut1 with SAT=1 (saturating).

module tb_syn_sum_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a, b, c, d;
    logic       cin;
    logic       sub;

    logic       in_ready0, out_valid0, ovf0;
    logic [7:0] sum0;
    logic [1:0] cout0;
    logic       in_ready1, out_valid1, ovf1;
    logic [7:0] sum1;
    logic [1:0] cout1;

    int checks;
    int failures;

    syn_sum_pipe #(.WIDTH(8), .SAT(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .sum       (sum0),
        .cout      (cout0),
        .ovf       (ovf0)
    );

    syn_sum_pipe #(.WIDTH(8), .SAT(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat, then check latency and both result flavours.
    task automatic beat(input string tag,
                        input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                        input logic [7:0] td, input logic tcin, input logic tsub,
                        input logic [7:0] e0_sum, input logic [1:0] e0_cout, input logic e0_ovf,
                        input logic [7:0] e1_sum, input logic [1:0] e1_cout, input logic e1_ovf);
        @(negedge clk);
        a = ta; b = tb; c = tc; d = td; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'hAA; b = 8'h55; c = 8'hAA; d = 8'h55; cin = 1'b1; sub = ~tsub;
        #1;
        chk({tag, "_not_early"}, out_valid0, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid0"}, out_valid0, 1);
        chk({tag, "_sum0"}, sum0, e0_sum);
        chk({tag, "_cout0"}, cout0, e0_cout);
        chk({tag, "_ovf0"}, ovf0, e0_ovf);
        chk({tag, "_valid1"}, out_valid1, 1);
        chk({tag, "_sum1"}, sum1, e1_sum);
        chk({tag, "_cout1"}, cout1, e1_cout);
        chk({tag, "_ovf1"}, ovf1, e1_ovf);
    endtask

    initial begin
        int         next_a;
        int         exp_out;
        logic       prev_hold;
        logic [7:0] prev_sum;
        logic       saw_block;
        logic       accept;
        logic       emit;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 8'd0; b = 8'd0; c = 8'd0; d = 8'd0; cin = 1'b0; sub = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cout", cout0, 0);
        chk("rst_ovf", ovf0, 0);
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", in_ready0, 0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        // Basic function and boundaries
        beat("add_basic", 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0,
             8'd10, 2'd0, 1'b0, 8'd10, 2'd0, 1'b0);
        beat("add_max", 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0,
             8'hFD, 2'd3, 1'b1, 8'hFF, 2'd0, 1'b1);
        beat("sub_neg", 8'd1, 8'd1, 8'd3, 8'd4, 1'b0, 1'b1,
             8'hFB, 2'd3, 1'b1, 8'h00, 2'd0, 1'b1);
        beat("sub_equal", 8'd3, 8'd2, 8'd1, 8'd4, 1'b0, 1'b1,
             8'd0, 2'd0, 1'b0, 8'd0, 2'd0, 1'b0);
        beat("sub_pos", 8'd10, 8'd5, 8'd3, 8'd4, 1'b1, 1'b1,
             8'd9, 2'd0, 1'b0, 8'd9, 2'd0, 1'b0);
        beat("add_edge255", 8'd200, 8'd55, 8'd0, 8'd0, 1'b0, 1'b0,
             8'd255, 2'd0, 1'b0, 8'd255, 2'd0, 1'b0);
        beat("add_edge256", 8'd200, 8'd55, 8'd0, 8'd0, 1'b1, 1'b0,
             8'd0, 2'd1, 1'b1, 8'hFF, 2'd0, 1'b1);

        // Streaming 1..10 with a stall in cycles 3-5
        @(negedge clk);
        next_a    = 1;
        exp_out   = 1;
        prev_hold = 1'b0;
        prev_sum  = 8'd0;
        saw_block = 1'b0;
        for (int t = 0; t < 40 && exp_out <= 10; t++) begin
            @(negedge clk);
            out_ready = !(t >= 3 && t <= 5);
            in_valid  = (next_a <= 10);
            a = 8'(next_a); b = 8'd0; c = 8'd0; d = 8'd0; cin = 1'b0; sub = 1'b0;
            #1;
            if (prev_hold) begin
                chk("stall_valid", out_valid0, 1);
                chk("stall_sum", sum0, prev_sum);
            end
            accept = in_valid && in_ready0;
            emit   = out_valid0 && out_ready;
            // Garbage on an operand while blocked must not be captured.
            if (in_valid && !in_ready0) begin
                saw_block = 1'b1;
                b = 8'd77;
            end
            if (emit) begin
                chk("stream_sum0", sum0, exp_out);
                chk("stream_sum1", sum1, exp_out);
                exp_out++;
            end
            prev_hold = out_valid0 && !out_ready;
            prev_sum  = sum0;
            if (accept) next_a++;
        end
        chk("stream_count", exp_out, 11);
        chk("stream_backpressure", saw_block, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stream_drained", out_valid0, 0);

        // Reset with two beats in flight
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'd5; b = 8'd0; c = 8'd0; d = 8'd0; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        a = 8'd6;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid0, 1);
        chk("pre_rst_sum", sum0, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid0, 0);
        chk("mid_rst_sum", sum0, 0);
        chk("mid_rst_cout", cout0, 0);
        chk("mid_rst_ovf", ovf0, 0);
        chk("mid_rst_in_ready", in_ready0, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_stale", out_valid0, 0);
        end
        beat("post_rst", 8'd1, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0,
             8'd2, 2'd0, 1'b0, 8'd2, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
